// File: rtl/gray_conv_pkg.sv
// Shared definitions for the Gray-code conversion arbiter: FSM states,
// operation mode encodings and the fixed requester count.
package gray_conv_pkg;

  // Number of requesters sharing the conversion unit (fixed, not a parameter).
  localparam int NREQ = 2;

  // Per-requester operation select.
  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Output slot occupancy: EMPTY means no result presented, FULL means
  // resp_valid is high.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/gray_conv_unit.sv
// Combinational binary<->Gray converter shared by all requesters.
module gray_conv_unit
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Convert din according to mode; Gray-to-binary bit i is the XOR of all
  // Gray bits from i up to the MSB, which is the MSB-first chain unrolled.
  always_comb begin
    dout = '0;
    if (mode == MODE_G2B) begin
      for (int i = 0; i < WIDTH; i++) begin
        dout[i] = ^(din >> i);
      end
    end else begin
      dout = din ^ (din >> 1);
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two requesters share one Gray-code conversion unit through a round-robin
// arbiter feeding a one-entry output register with valid/ready handshake.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [WIDTH-1:0]      resp_data
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             slot_free_s;
  logic             grant_s;
  logic             grant_id_s;
  logic             conv_mode_s;
  logic [WIDTH-1:0] conv_din_s;
  logic [WIDTH-1:0] conv_dout_s;

  // In EMPTY the slot is free regardless of resp_ready, so req_ready has no
  // path from resp_ready in that state.
  assign slot_free_s = (state_q == EMPTY) || resp_ready;

  // Round-robin arbitration: a lone requester always wins, the pointer
  // breaks ties; the grant is suppressed during reset.
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = ptr_q;
    req_ready  = '0;
    case (req_valid)
      2'b01: begin
        grant_s    = slot_free_s;
        grant_id_s = 1'b0;
      end
      2'b10: begin
        grant_s    = slot_free_s;
        grant_id_s = 1'b1;
      end
      2'b11: begin
        grant_s    = slot_free_s;
        grant_id_s = ptr_q;
      end
      default: begin
        grant_s    = 1'b0;
        grant_id_s = ptr_q;
      end
    endcase
    if (grant_s && !rst) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Route the winner's operand and mode into the single shared converter.
  assign conv_din_s  = grant_id_s ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
  assign conv_mode_s = req_mode[grant_id_s];

  gray_conv_unit #(
    .WIDTH(WIDTH)
  ) u_conv (
    .mode(conv_mode_s),
    .din (conv_din_s),
    .dout(conv_dout_s)
  );

  // Slot FSM: a grant loads the register (also while draining, keeping one
  // result per cycle); a drain without grant empties it; otherwise hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (grant_s) begin
          state_d = FULL;
          data_d  = conv_dout_s;
          id_d    = grant_id_s;
          ptr_d   = ~grant_id_s;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (grant_s) begin
          state_d = FULL;
          data_d  = conv_dout_s;
          id_d    = grant_id_s;
          ptr_d   = ~grant_id_s;
        end else if (resp_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and result registers; reset discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_id    = id_q;
  assign resp_data  = data_q;

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 3, code width in bits (legal range 2..16).
REQ-002 Parameter NREQ, fixed at 2, number of requesters (not overridable).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 req_mode  input  2  per-requester op: 0 = binary-to-gray, 1 = gray-to-binary.
REQ-007 req_data  input  2*WIDTH  per-requester operand; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  2  per-requester accept; transfer when req_valid[i] & req_ready[i].
REQ-009 resp_valid  output  1  result held in output register.
REQ-010 resp_ready  input  1  downstream accept; transfer when resp_valid & resp_ready.
REQ-011 resp_id  output  1  index of the requester whose result is presented.
REQ-012 resp_data  output  WIDTH  converted code.

Function
REQ-013 Shall share one conversion unit between both requesters, using a one-entry output register.
REQ-014 Binary-to-gray: g[W-1]=b[W-1]; g[i]=b[i+1]^b[i] for i<W-1.
REQ-015 Gray-to-binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i], evaluated MSB to LSB.
REQ-016 Two-state FSM: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-017 Slot is free when state is EMPTY, or state is FULL with resp_ready=1 in that cycle.
REQ-018 At most one req_ready bit is high per cycle; req_ready[i]=1 only if the slot is free, req_valid[i]=1 and requester i wins arbitration.
REQ-019 req_ready shall not depend on resp_ready when state is EMPTY.
REQ-020 Arbitration: round-robin with a 1-bit priority pointer; the pointed requester wins a tie.
REQ-021 A lone valid requester wins regardless of the pointer.
REQ-022 After a grant to requester i, pointer shall become 1-i; the pointer is unchanged when no grant occurs.
REQ-023 On a grant, resp_data, resp_id and state FULL shall be registered the same edge; latency from accept to resp_valid is 1 cycle.
REQ-024 Simultaneous drain and grant shall keep state FULL with new contents, sustaining 1 result per cycle.
REQ-025 Drain without grant: FULL -> EMPTY.
REQ-026 While resp_valid=1 and resp_ready=0, resp_data and resp_id shall hold stable.
REQ-027 Requesters may drop req_valid without handshake; the block never latches unaccepted data.

Reset
REQ-028 On rst=1 at a clock edge: state EMPTY, resp_valid=0, resp_data=0, resp_id=0, pointer=0.
REQ-029 While rst=1, req_ready shall be 0.
REQ-030 Reset mid-transfer shall discard any held result without presenting it.

Structure
REQ-031 Shared package gray_conv_pkg holds the FSM state enum (EMPTY, FULL) and the mode constants MODE_B2G=0 and MODE_G2B=1.
REQ-032 Conversion shall be a combinational sub-module gray_conv_unit (WIDTH, mode, din, dout), instantiated once.

Verification
REQ-033 WIDTH=3, req0 mode 0 data 3'b101, resp_ready=1 -> next cycle resp_valid=1, resp_data=3'b111, resp_id=0.
REQ-034 req1 mode 1 data 3'b111 -> resp_data=3'b101, resp_id=1; exhaustive 0..7 round-trip b2g then g2b returns the input.
REQ-035 Both valid every cycle, resp_ready=1, after reset -> grants alternate 0,1,0,1; one result per cycle.
REQ-036 Result held with resp_ready=0 for 3 cycles -> resp_data/resp_id stable, req_ready=00; raise resp_ready -> drain plus new grant in the same cycle.
REQ-037 Assert rst while FULL -> next cycle resp_valid=0, resp_data=0, pointer=0; first grant after reset with both valid goes to requester 0.
